// File: rtl/load_store_unit.sv
// Per-thread load/store unit: runs one valid/ready data-memory
// transaction per LDR/STR and returns loaded data as lsu_out.
module load_store_unit #(
   parameter int data_bits = 8,
   parameter int addr_bits = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [7:0]           rs,
   input  logic [7:0]           rt,
   output logic                 mem_read_valid,
   output logic [addr_bits-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [data_bits-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [addr_bits-1:0] mem_write_address,
   output logic [data_bits-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [data_bits-1:0] lsu_out
);

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      REQUESTING = 2'b01,
      WAITING    = 2'b10,
      DONE       = 2'b11
   } state_t;

   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   state_t state;
   logic   op_load;

   assign lsu_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         op_load           <= 1'b0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         lsu_out           <= '0;
      end else if (enable) begin
         unique case (state)
            IDLE: begin
               if (core_state == CORE_REQUEST &&
                   (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                  op_load <= decoded_mem_read_enable;
                  state   <= REQUESTING;
               end
            end
            // rs/rt are only valid one cycle after REQUEST
            REQUESTING: begin
               if (op_load) begin
                  mem_read_valid   <= 1'b1;
                  mem_read_address <= addr_bits'(rs);
               end else begin
                  mem_write_valid   <= 1'b1;
                  mem_write_address <= addr_bits'(rs);
                  mem_write_data    <= data_bits'(rt);
               end
               state <= WAITING;
            end
            WAITING: begin
               if (op_load && mem_read_ready) begin
                  lsu_out        <= mem_read_data;
                  mem_read_valid <= 1'b0;
                  state          <= DONE;
               end else if (!op_load && mem_write_ready) begin
                  mem_write_valid <= 1'b0;
                  state           <= DONE;
               end
            end
            DONE: begin
               if (core_state == CORE_UPDATE) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized checks of load_store_unit against a
// transaction-level model of the expected handshake timeline.
module tb_load_store_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] core_state;
   logic       rd_en;
   logic       wr_en;
   logic [7:0] rs;
   logic [7:0] rt;
   logic       mem_read_valid;
   logic [7:0] mem_read_address;
   logic       mem_read_ready;
   logic [7:0] mem_read_data;
   logic       mem_write_valid;
   logic [7:0] mem_write_address;
   logic [7:0] mem_write_data;
   logic       mem_write_ready;
   logic [1:0] lsu_state;
   logic [7:0] lsu_out;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_out;

   localparam logic [2:0] C_IDLE = 3'b000;
   localparam logic [2:0] C_REQ  = 3'b011;
   localparam logic [2:0] C_WAIT = 3'b100;
   localparam logic [2:0] C_EXE  = 3'b101;
   localparam logic [2:0] C_UPD  = 3'b110;

   always #5 clk = ~clk;

   load_store_unit #(.data_bits(8), .addr_bits(8)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_mem_read_enable  (rd_en),
      .decoded_mem_write_enable (wr_en),
      .rs                       (rs),
      .rt                       (rt),
      .mem_read_valid           (mem_read_valid),
      .mem_read_address         (mem_read_address),
      .mem_read_ready           (mem_read_ready),
      .mem_read_data            (mem_read_data),
      .mem_write_valid          (mem_write_valid),
      .mem_write_address        (mem_write_address),
      .mem_write_data           (mem_write_data),
      .mem_write_ready          (mem_write_ready),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_state"}, 32'(lsu_state), 32'd0);
      chk({tag, "_rv"}, 32'(mem_read_valid), 32'd0);
      chk({tag, "_wv"}, 32'(mem_write_valid), 32'd0);
   endtask

   // Expected bus contents for an in-flight op
   task automatic chk_wait(input string tag, input bit ld,
                           input logic [7:0] a, input logic [7:0] d);
      chk({tag, "_state"}, 32'(lsu_state), 32'd2);
      chk({tag, "_rv"}, 32'(mem_read_valid), 32'(ld));
      chk({tag, "_wv"}, 32'(mem_write_valid), 32'(!ld));
      if (ld) chk({tag, "_raddr"}, 32'(mem_read_address), 32'(a));
      else begin
         chk({tag, "_waddr"}, 32'(mem_write_address), 32'(a));
         chk({tag, "_wdata"}, 32'(mem_write_data), 32'(d));
      end
   endtask

   task automatic txn(input bit rd, input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] md,
                      input int wn, input int gap);
      bit ld;
      bit st;
      ld = rd;
      st = !rd && wr;
      core_state = C_REQ;
      rd_en = rd;
      wr_en = wr;
      rs = $urandom;
      rt = $urandom;
      step();
      if (!ld && !st) begin
         chk_idle_outputs("noop_req");
         core_state = C_EXE;
         rd_en = 1'b0;
         step();
         chk_idle_outputs("noop_exe");
         core_state = C_IDLE;
         return;
      end
      chk("req_state", 32'(lsu_state), 32'd1);
      chk("req_rv", 32'(mem_read_valid), 32'd0);
      chk("req_wv", 32'(mem_write_valid), 32'd0);
      core_state = C_WAIT;
      rd_en = 1'b0;
      wr_en = 1'b0;
      rs = a;
      rt = d;
      step();
      chk_wait("issue", ld, a, d);
      rs = ~a;
      rt = ~d;
      for (int i = 0; i < wn; i++) begin
         if (i == 0 && gap > 0) begin
            enable = 1'b0;
            mem_read_ready = 1'b1;
            mem_write_ready = 1'b1;
            mem_read_data = ~md;
            for (int g = 0; g < gap; g++) begin
               step();
               chk_wait("gap", ld, a, d);
            end
            enable = 1'b1;
         end
         mem_read_data = $urandom;
         mem_read_ready = st;
         mem_write_ready = ld;
         step();
         chk_wait("hold", ld, a, d);
      end
      mem_read_ready = ld;
      mem_write_ready = st;
      mem_read_data = md;
      step();
      if (ld) exp_out = md;
      chk("cmp_state", 32'(lsu_state), 32'd3);
      chk("cmp_rv", 32'(mem_read_valid), 32'd0);
      chk("cmp_wv", 32'(mem_write_valid), 32'd0);
      chk("cmp_out", 32'(lsu_out), 32'(exp_out));
      mem_read_ready = 1'b1;
      mem_write_ready = 1'b1;
      mem_read_data = $urandom;
      core_state = C_EXE;
      step();
      chk("done_state", 32'(lsu_state), 32'd3);
      chk("done_out", 32'(lsu_out), 32'(exp_out));
      mem_read_ready = 1'b0;
      mem_write_ready = 1'b0;
      core_state = C_UPD;
      step();
      chk_idle_outputs("upd");
      chk("upd_out", 32'(lsu_out), 32'(exp_out));
      core_state = C_IDLE;
   endtask

   initial begin
      // Reset with garbage on every input
      reset = 1'b1;
      enable = 1'b1;
      core_state = C_REQ;
      rd_en = 1'b1;
      wr_en = 1'b1;
      rs = 8'hA5;
      rt = 8'h3C;
      mem_read_ready = 1'b1;
      mem_write_ready = 1'b1;
      mem_read_data = 8'h77;
      step();
      step();
      exp_out = 8'h00;
      chk_idle_outputs("rst");
      chk("rst_raddr", 32'(mem_read_address), 32'd0);
      chk("rst_waddr", 32'(mem_write_address), 32'd0);
      chk("rst_wdata", 32'(mem_write_data), 32'd0);
      chk("rst_out", 32'(lsu_out), 32'd0);
      reset = 1'b0;
      core_state = C_IDLE;
      rd_en = 1'b0;
      wr_en = 1'b0;
      mem_read_ready = 1'b0;
      mem_write_ready = 1'b0;
      step();
      chk_idle_outputs("post_rst");

      txn(1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 0, 0);
      txn(1'b0, 1'b1, 8'h10, 8'hF0, 8'hEE, 4, 0);
      txn(1'b1, 1'b1, 8'h33, 8'h44, 8'h91, 1, 0);
      txn(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0);
      txn(1'b1, 1'b0, 8'h81, 8'h00, 8'hC3, 1, 3);
      txn(1'b0, 1'b1, 8'h82, 8'h19, 8'h00, 2, 3);

      // Reset landing in WAITING
      core_state = C_REQ;
      rd_en = 1'b1;
      step();
      core_state = C_WAIT;
      rd_en = 1'b0;
      rs = 8'h66;
      step();
      chk_wait("pre_rst", 1'b1, 8'h66, 8'h00);
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_out = 8'h00;
      chk_idle_outputs("wait_rst");
      chk("wait_rst_out", 32'(lsu_out), 32'd0);
      core_state = C_IDLE;
      step();

      for (int k = 0; k < 40; k++) begin
         int wn;
         wn = $urandom_range(0, 4);
         txn(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), wn, (wn > 0 && $urandom_range(0, 2) == 0) ?
             $urandom_range(1, 3) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
